timer_arbiter: RTL and testbench



---
 rtl/vm_pkg.sv | 14 +
 rtl/tick_gen.sv | 28 ++
 rtl/timer_arbiter.sv | 132 +++++++++++++
 tb/tb_timer_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding and default geometry.
package vm_pkg;

    localparam int unsigned TICK_DIV_DEF = 100000;
    localparam int          NREQ_DEF     = 4;
    localparam int          DUR_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Timebase prescaler: free-running 0..TICK_DIV-1 counter with a synchronous
// clear; tick is high for the single cycle the counter sits at its top value.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] TC = 32'(TICK_DIV - 1);

    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == TC) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign tick = (cnt_q == TC);

endmodule

// File: rtl/timer_arbiter.sv
// One shared tick-based timer handed round-robin to NREQ requesters; the owner
// gets a done pulse after its requested number of ticks unless it aborts first.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no owner; pick the next requester round-robin from last_grant
//   ST_RUN  | owner holds grant, remaining counts down on each tick
//   ST_DONE | one cycle: done pulse to owner, grant still held
module timer_arbiter
    import vm_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int          NREQ     = NREQ_DEF,
    parameter int          DUR_W    = DUR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DUR_W-1:0] dur,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [DUR_W-1:0]      remaining,
    output logic                  tick
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // First asserted request scanning upward from last+1, wrapping; the
    // previous owner is therefore always considered last.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDXW-1:0] last);
        logic [IDXW-1:0] pick;
        int              j;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(last) + i) % NREQ;
            if (r[j]) pick = IDXW'(j);
        end
        return pick;
    endfunction

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   sel_q, sel_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic              armed_q;
    logic              prescale_clr;
    logic [IDXW-1:0]   pick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (prescale_clr),
        .tick  (tick)
    );

    // armed_q holds off the very first grant by one cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            rem_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        last_d       = last_q;
        rem_d        = rem_q;
        prescale_clr = 1'b0;
        pick         = rr_pick(req, last_q);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && (|req)) begin
                    state_d       = ST_RUN;
                    sel_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    rem_d         = dur[int'(pick)*DUR_W +: DUR_W];
                    prescale_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort takes precedence over reaching zero.
                if (!req[sel_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                    last_d  = sel_q;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                rem_d   = '0;
                last_d  = sel_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                rem_d   = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = (state_q == ST_DONE) ? grant_q : '0;
    assign busy      = |grant_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected grant/done events are queued as
// stimulus is driven and matched (vector and cycle) when the DUT produces them.
module tb_timer_arbiter;

    localparam int TD = 4;
    localparam int NR = 4;
    localparam int DW = 16;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req   = '0;
    logic [NR*DW-1:0] dur   = '0;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             busy;
    logic [DW-1:0]    remaining;
    logic             tick;

    timer_arbiter #(
        .TICK_DIV (TD),
        .NREQ     (NR),
        .DUR_W    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dur       (dur),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         is_done;
        logic [3:0] vec;
        int         cyc;
    } ev_t;

    ev_t sb[$];

    task automatic push(input bit is_done, input logic [3:0] vec, input int c);
        ev_t e;
        e.is_done = is_done;
        e.vec     = vec;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    task automatic observe(input bit is_done, input logic [3:0] vec);
        ev_t e;
        if (sb.size() == 0) begin
            check(is_done ? "spurious_done" : "spurious_grant", 32'(vec), 32'd0);
        end else begin
            e = sb.pop_front();
            check("ev_kind", 32'(is_done), 32'(e.is_done));
            check("ev_vec", 32'(vec), 32'(e.vec));
            check("ev_cyc", cyc, e.cyc);
        end
    endtask

    logic [3:0] prev_grant = '0;
    always @(posedge clk) begin
        #1;
        check("grant_onehot", 32'($onehot0(grant)), 32'd1);
        if (grant != '0 && prev_grant == '0) observe(1'b0, grant);
        if (done != '0) observe(1'b1, done);
        prev_grant = grant;
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_dur(input int i, input int d);
        dur[i*DW +: DW] = DW'(d);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("sb_drain", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, m;
        logic [3:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Round-robin from reset pointer: 0,1,2,3, dur 1 each
        n = cyc;
        for (int i = 0; i < NR; i++) set_dur(i, 1);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            g = n + 1 + 7 * k;
            push(1'b0, 4'(1 << k), g);
            push(1'b1, 4'(1 << k), g + 5);
        end
        goto(n + 1);
        check("rr_remaining_g", 32'(remaining), 32'd1);
        check("rr_busy_g", 32'(busy), 32'd1);
        goto(n + 3);
        check("rr_tick_g2", 32'(tick), 32'd0);
        goto(n + 4);
        check("rr_tick_g3", 32'(tick), 32'd1);
        for (int k = 0; k < 4; k++) begin
            goto(n + 1 + 7 * k + 5);
            req[k] = 1'b0;
        end
        drain(40);

        // Abort: req0 dur 5 drops at g+6, pending req3 follows at g+8
        n = cyc;
        set_dur(0, 5);
        set_dur(3, 2);
        req = 4'b1001;
        g = n + 1;
        push(1'b0, 4'b0001, g);
        push(1'b0, 4'b1000, g + 8);
        push(1'b1, 4'b1000, g + 17);
        goto(g + 6);
        req[0] = 1'b0;
        goto(g + 7);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_remaining", 32'(remaining), 32'd0);
        goto(g + 17);
        req[3] = 1'b0;
        drain(40);

        // Single: req1 dur 3, done at g+13
        n = cyc;
        set_dur(1, 3);
        req = 4'b0010;
        g = n + 1;
        push(1'b0, 4'b0010, g);
        push(1'b1, 4'b0010, g + 13);
        goto(g);      check("single_rem_0", 32'(remaining), 32'd3);
        goto(g + 3);  check("single_rem_3", 32'(remaining), 32'd3);
        goto(g + 4);  check("single_rem_4", 32'(remaining), 32'd2);
        goto(g + 8);  check("single_rem_8", 32'(remaining), 32'd1);
        goto(g + 11); check("single_rem_11", 32'(remaining), 32'd1);
        goto(g + 12); check("single_rem_12", 32'(remaining), 32'd0);
        goto(g + 13);
        req = '0;
        goto(g + 14);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_rem", 32'(remaining), 32'd0);
        drain(40);

        // Zero duration: req2 dur 0, done at g+1, idle at g+2
        n = cyc;
        set_dur(2, 0);
        req = 4'b0100;
        g = n + 1;
        push(1'b0, 4'b0100, g);
        push(1'b1, 4'b0100, g + 1);
        goto(g);
        check("zero_rem", 32'(remaining), 32'd0);
        check("zero_busy", 32'(busy), 32'd1);
        goto(g + 1);
        req = '0;
        goto(g + 2);
        check("zero_idle", 32'(grant), 32'd0);
        drain(20);

        // Re-request: req0 and req1 held, grants alternate 0,1,0,1
        n = cyc;
        set_dur(0, 1);
        set_dur(1, 1);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            g = n + 1 + 7 * k;
            v = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            push(1'b0, v, g);
            push(1'b1, v, g + 5);
        end
        for (int k = 0; k < 3; k++) begin
            goto(n + 1 + 7 * k + 6);
            check("rereq_gap", 32'(grant), 32'd0);
        end
        goto(n + 1 + 21 + 5);
        req = '0;
        drain(40);

        // Reset mid-RUN, then req1/req2 after release
        n = cyc;
        set_dur(1, 2);
        req = 4'b0010;
        g = n + 1;
        push(1'b0, 4'b0010, g);
        goto(g + 5);
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rem", 32'(remaining), 32'd0);
        check("mid_rst_tick", 32'(tick), 32'd0);
        req = 4'b0110;
        set_dur(2, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m = cyc;
        push(1'b0, 4'b0010, m + 2);
        push(1'b1, 4'b0010, m + 11);
        push(1'b0, 4'b0100, m + 13);
        push(1'b1, 4'b0100, m + 14);
        goto(m + 1);
        check("post_rst_hold", 32'(grant), 32'd0);
        goto(m + 2);
        check("post_rst_rem", 32'(remaining), 32'd2);
        goto(m + 11);
        req[1] = 1'b0;
        goto(m + 14);
        req[2] = 1'b0;
        drain(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
